// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity, stop period.
// Advances only on the 16x-oversampled baud tick; tx_o is registered and idles high.
module uart_tx_ctrl #(
  parameter int DataBits  = 8,
  parameter int SbTick    = 16,
  parameter int ParityEn  = 0,
  parameter int ParityOdd = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_tick_i,
  input  logic                tx_start_i,
  input  logic [DataBits-1:0] din_i,
  output logic                tx_o,
  output logic                busy_o,
  output logic                tx_done_tick_o
);

  localparam int NW = (DataBits > 1) ? $clog2(DataBits) : 1;
  localparam logic [NW-1:0] LAST_BIT = NW'(DataBits - 1);
  localparam logic [4:0]    BIT_LAST = 5'd15;
  localparam logic [4:0]    SB_LAST  = 5'(SbTick - 1);
  localparam logic          PAR_INV  = (ParityOdd != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              r_state;
  logic [4:0]          r_s_cnt;
  logic [NW-1:0]       r_n_cnt;
  logic [DataBits-1:0] r_b_reg;
  logic                r_p_reg;
  logic                r_tx_reg;
  logic                r_done;

  // r_tx_reg is loaded with the level of the state being entered so the line
  // changes on the same edge as the state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_s_cnt  <= '0;
      r_n_cnt  <= '0;
      r_b_reg  <= '0;
      r_p_reg  <= 1'b0;
      r_tx_reg <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_reg <= 1'b1;
          if (tx_start_i) begin
            r_b_reg  <= din_i;
            r_p_reg  <= (^din_i) ^ PAR_INV;
            r_s_cnt  <= '0;
            r_state  <= START;
            r_tx_reg <= 1'b0;
          end
        end
        START: begin
          if (s_tick_i) begin
            if (r_s_cnt == BIT_LAST) begin
              r_s_cnt  <= '0;
              r_n_cnt  <= '0;
              r_state  <= DATA;
              r_tx_reg <= r_b_reg[0];
            end else begin
              r_s_cnt <= r_s_cnt + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick_i) begin
            if (r_s_cnt == BIT_LAST) begin
              r_s_cnt <= '0;
              r_b_reg <= r_b_reg >> 1;
              if (r_n_cnt == LAST_BIT) begin
                if (ParityEn != 0) begin
                  r_state  <= PARITY;
                  r_tx_reg <= r_p_reg;
                end else begin
                  r_state  <= STOP;
                  r_tx_reg <= 1'b1;
                end
              end else begin
                r_n_cnt  <= r_n_cnt + 1'b1;
                r_tx_reg <= r_b_reg[1];
              end
            end else begin
              r_s_cnt <= r_s_cnt + 5'd1;
            end
          end
        end
        PARITY: begin
          if (s_tick_i) begin
            if (r_s_cnt == BIT_LAST) begin
              r_s_cnt  <= '0;
              r_state  <= STOP;
              r_tx_reg <= 1'b1;
            end else begin
              r_s_cnt <= r_s_cnt + 5'd1;
            end
          end
        end
        STOP: begin
          r_tx_reg <= 1'b1;
          if (s_tick_i) begin
            if (r_s_cnt == SB_LAST) begin
              r_s_cnt <= '0;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_s_cnt <= r_s_cnt + 5'd1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_tx_reg <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o           = r_tx_reg;
  assign busy_o         = (r_state != IDLE);
  assign tx_done_tick_o = r_done;

endmodule
